// File: rtl/ttt_move_scheduler.sv
// Tic-tac-toe move scheduler: conditions the nine cell buttons, arbitrates presses and issues one move per turn.
// Optional per-turn timeout is built only when TTT_TURN_TIMEOUT_EN is defined.
module ttt_move_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [8:0] i_buttons,
  input  logic [8:0] i_occupied,
  input  logic       i_move_ready,
  input  logic       i_result_valid,
  input  logic       i_result_win,
  input  logic       i_result_draw,
  output logic       o_move_valid,
  output logic [3:0] o_move_cell,
  output logic       o_move_player,
  output logic       o_curr_player,
  output logic       o_game_active,
  output logic       o_game_over,
  output logic [1:0] o_winner,
  output logic       o_rejected,
  output logic       o_turn_skipped
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ISSUE,
    S_WAIT_RES,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [8:0]      r_sync1;
  logic [8:0]      r_sync2;
  logic [8:0]      r_dbLevel;
  logic [8:0]      r_dbPrev;
  logic [8:0]      r_pressEvt;
  logic [DB_W-1:0] r_dbCnt [9];
  logic            w_anyPress;
  logic [3:0]      w_pick;

`ifdef TTT_TURN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] r_turnCnt;
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign o_turn_skipped  = 1'b0;
`endif

  // A debounce counter only runs while the synchronised level disagrees with the accepted level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_dbLevel  <= '0;
      r_dbPrev   <= '0;
      r_pressEvt <= '0;
      for (int i = 0; i < 9; i++) begin
        r_dbCnt[i] <= '0;
      end
    end else begin
      r_sync1    <= i_buttons;
      r_sync2    <= r_sync1;
      r_dbPrev   <= r_dbLevel;
      r_pressEvt <= r_dbLevel & ~r_dbPrev;
      for (int i = 0; i < 9; i++) begin
        if (r_sync2[i] == r_dbLevel[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_dbLevel[i] <= r_sync2[i];
          r_dbCnt[i]   <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Lowest-index press wins; losing presses are simply dropped.
  always_comb begin
    w_anyPress = 1'b0;
    w_pick     = '0;
    for (int i = 8; i >= 0; i--) begin
      if (r_pressEvt[i]) begin
        w_anyPress = 1'b1;
        w_pick     = 4'(i);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      o_move_valid  <= 1'b0;
      o_move_cell   <= '0;
      o_move_player <= 1'b0;
      o_curr_player <= 1'b0;
      o_game_active <= 1'b0;
      o_game_over   <= 1'b0;
      o_winner      <= 2'b00;
      o_rejected    <= 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
      o_turn_skipped <= 1'b0;
      r_turnCnt      <= '0;
`endif
    end else begin
      o_rejected <= 1'b0;
`ifdef TTT_TURN_TIMEOUT_EN
      o_turn_skipped <= 1'b0;
`endif
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state       <= S_ARMED;
            o_game_active <= 1'b1;
            o_game_over   <= 1'b0;
            o_curr_player <= 1'b0;
            o_winner      <= 2'b00;
`ifdef TTT_TURN_TIMEOUT_EN
            r_turnCnt <= '0;
`endif
          end
        end
        S_ARMED: begin
          if (w_anyPress) begin
            if (i_occupied[w_pick]) begin
              o_rejected <= 1'b1;
`ifdef TTT_TURN_TIMEOUT_EN
              r_turnCnt <= '0;
`endif
            end else begin
              o_move_cell   <= w_pick;
              o_move_player <= o_curr_player;
              o_move_valid  <= 1'b1;
              r_state       <= S_ISSUE;
            end
          end
`ifdef TTT_TURN_TIMEOUT_EN
          else if (r_turnCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            o_turn_skipped <= 1'b1;
            o_curr_player  <= ~o_curr_player;
            r_turnCnt      <= '0;
          end else begin
            r_turnCnt <= r_turnCnt + TO_W'(1);
          end
`endif
        end
        S_ISSUE: begin
          if (i_move_ready) begin
            o_move_valid <= 1'b0;
            r_state      <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          // A win outranks a simultaneous draw flag.
          if (i_result_valid) begin
            if (i_result_win) begin
              o_winner      <= o_curr_player ? 2'b10 : 2'b01;
              o_game_active <= 1'b0;
              o_game_over   <= 1'b1;
              r_state       <= S_DONE;
            end else if (i_result_draw) begin
              o_winner      <= 2'b11;
              o_game_active <= 1'b0;
              o_game_over   <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              o_curr_player <= ~o_curr_player;
              r_state       <= S_ARMED;
`ifdef TTT_TURN_TIMEOUT_EN
              r_turnCnt <= '0;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_move_scheduler.sv
// Bench for ttt_move_scheduler: directed game scenarios plus random stimulus, all checked
// every cycle against a history-window/turn-flow model of the scheduler.
`timescale 1ns/1ps
module tb_ttt_move_scheduler;

  localparam int DEB = 4;
  localparam int TMO = 16;
  localparam int PH_IDLE = 0, PH_ARMED = 1, PH_ISSUE = 2, PH_WAIT = 3, PH_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] buttons = '0;
  logic [8:0] occupied = '0;
  logic       ready = 1'b0;
  logic       rv = 1'b0;
  logic       win = 1'b0;
  logic       draw = 1'b0;
  logic       moveValid, movePlayer, currPlayer, gameActive, gameOver, rejected, turnSkipped;
  logic [3:0] moveCell;
  logic [1:0] winner;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b1;

  ttt_move_scheduler #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_buttons(buttons), .i_occupied(occupied),
    .i_move_ready(ready), .i_result_valid(rv), .i_result_win(win), .i_result_draw(draw),
    .o_move_valid(moveValid), .o_move_cell(moveCell), .o_move_player(movePlayer),
    .o_curr_player(currPlayer), .o_game_active(gameActive), .o_game_over(gameOver),
    .o_winner(winner), .o_rejected(rejected), .o_turn_skipped(turnSkipped)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] b, input logic [8:0] occ, input logic rdy,
                               input logic rValid, input logic rWin, input logic rDraw,
                               input logic st);
    @(negedge clk);
    #1;
    buttons  = b;
    occupied = occ;
    ready    = rdy;
    rv       = rValid;
    win      = rWin;
    draw     = rDraw;
    start    = st;
  endtask

  // Reference model: button sample history (index k = sampled k edges ago) and turn flow.
  bit [8:0] sHist [6];
  bit [8:0] mDb = '0, mDbPrev = '0, mEvt = '0, mNewDb, mNewEvt;
  int mPhase = PH_IDLE, mCell = 0, mWinner = 0, mWait = 0, mPick;
  bit mCurr = 0, mValid = 0, mMovePlayer = 0, mRej = 0, mSkip = 0, mAllOpp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 6; k++) sHist[k] = '0;
      mDb = '0; mDbPrev = '0; mEvt = '0;
      mPhase = PH_IDLE; mCell = 0; mWinner = 0; mWait = 0;
      mCurr = 0; mValid = 0; mMovePlayer = 0; mRej = 0; mSkip = 0;
    end else begin
      mPick = -1;
      for (int i = 8; i >= 0; i--) if (mEvt[i]) mPick = i;
      mRej = 0;
      mSkip = 0;
      case (mPhase)
        PH_IDLE, PH_DONE: if (start) begin
          mPhase = PH_ARMED; mCurr = 0; mWinner = 0; mWait = 0;
        end
        PH_ARMED: begin
          if (mPick >= 0) begin
            if (occupied[mPick]) begin
              mRej = 1; mWait = 0;
            end else begin
              mCell = mPick; mMovePlayer = mCurr; mValid = 1; mPhase = PH_ISSUE;
            end
          end else begin
`ifdef TTT_TURN_TIMEOUT_EN
            mWait++;
            if (mWait == TMO) begin
              mSkip = 1; mCurr = ~mCurr; mWait = 0;
            end
`endif
          end
        end
        PH_ISSUE: if (ready) begin
          mValid = 0; mPhase = PH_WAIT;
        end
        PH_WAIT: if (rv) begin
          if (win) begin
            mWinner = mCurr ? 2 : 1; mPhase = PH_DONE;
          end else if (draw) begin
            mWinner = 3; mPhase = PH_DONE;
          end else begin
            mCurr = ~mCurr; mPhase = PH_ARMED; mWait = 0;
          end
        end
        default: mPhase = PH_IDLE;
      endcase
      for (int k = 5; k > 0; k--) sHist[k] = sHist[k-1];
      sHist[0] = buttons;
      mNewEvt = mDb & ~mDbPrev;
      mNewDb = mDb;
      for (int i = 0; i < 9; i++) begin
        mAllOpp = 1;
        for (int k = 2; k < 2 + DEB; k++) if (sHist[k][i] == mDb[i]) mAllOpp = 0;
        if (mAllOpp) mNewDb[i] = ~mDb[i];
      end
      mDbPrev = mDb;
      mDb = mNewDb;
      mEvt = mNewEvt;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("move_valid", moveValid, mValid);
      checkOutput("move_cell", moveCell, mCell);
      checkOutput("move_player", movePlayer, mMovePlayer);
      checkOutput("curr_player", currPlayer, mCurr);
      checkOutput("game_active", gameActive, (mPhase == PH_ARMED || mPhase == PH_ISSUE || mPhase == PH_WAIT));
      checkOutput("game_over", gameOver, (mPhase == PH_DONE));
      checkOutput("winner", winner, (mPhase == PH_DONE) ? mWinner : 0);
      checkOutput("rejected", rejected, mRej);
      checkOutput("turn_skipped", turnSkipped, mSkip);
    end
  end

  int firstValid, seenValid, seenRej, seenSkip;
  logic [8:0] rb;
  int hold;

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_active", gameActive, 0);
    checkOutput("rst_valid", moveValid, 0);
    checkOutput("rst_winner", winner, 0);

    // Start, then abort mid-game with reset, then start again.
    applyStimulus(9'h000, 9'h000, 1, 0, 0, 0, 1);
    applyStimulus(9'h000, 9'h000, 1, 0, 0, 0, 0);
    checkOutput("t1_active", gameActive, 1);
    checkOutput("t1_curr", currPlayer, 0);
    checkOutput("t1_valid", moveValid, 0);
    checkOutput("t1_over", gameOver, 0);
    checkOutput("t1_winner", winner, 0);
    checkOutput("t1_rejected", rejected, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 checkOutput("t1_reset_active", gameActive, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(9'h000, 9'h000, 1, 0, 0, 0, 1);
    applyStimulus(9'h000, 9'h000, 1, 0, 0, 0, 0);
    checkOutput("t1_restart_active", gameActive, 1);

    // Clean press of cell 4: latency and move contents.
    firstValid = -1;
    for (int m = 1; m <= 20; m++) begin
      applyStimulus(m <= 6 ? 9'h010 : 9'h000, 9'h000, 1, 0, 0, 0, 0);
      if (moveValid && firstValid < 0) begin
        firstValid = m;
        checkOutput("t2_cell", moveCell, 4);
        checkOutput("t2_player", movePlayer, 0);
      end
    end
    checkOutput("t2_latency", firstValid - 1, 8);
    applyStimulus(9'h000, 9'h010, 1, 1, 0, 0, 0);
    applyStimulus(9'h000, 9'h010, 1, 0, 0, 0, 0);
    checkOutput("t2_curr", currPlayer, 1);

    // Cells 2 and 7 together: only cell 2 is issued.
    seenValid = 0;
    for (int m = 1; m <= 20; m++) begin
      applyStimulus(m <= 6 ? 9'h084 : 9'h000, 9'h010, 1, 0, 0, 0, 0);
      if (moveValid) begin
        seenValid++;
        checkOutput("t3_cell", moveCell, 2);
        checkOutput("t3_player", movePlayer, 1);
      end
    end
    checkOutput("t3_valid_count", seenValid, 1);
    applyStimulus(9'h000, 9'h014, 1, 1, 0, 0, 0);
    applyStimulus(9'h000, 9'h014, 1, 0, 0, 0, 0);
    checkOutput("t3_curr", currPlayer, 0);

    // Press on an occupied cell is rejected.
    seenValid = 0;
    seenRej = 0;
    for (int m = 1; m <= 12; m++) begin
      applyStimulus(m <= 6 ? 9'h010 : 9'h000, 9'h094, 1, 0, 0, 0, 0);
      seenValid += int'(moveValid);
      seenRej += int'(rejected);
    end
    checkOutput("t4_rejects", seenRej, 1);
    checkOutput("t4_valid_count", seenValid, 0);
`ifndef TTT_TURN_TIMEOUT_EN
    checkOutput("t4_curr", currPlayer, 0);
`endif

    // A 3-cycle bounce never becomes a press.
    seenValid = 0;
    for (int m = 1; m <= 10; m++) begin
      applyStimulus(m <= 3 ? 9'h020 : 9'h000, 9'h094, 1, 0, 0, 0, 0);
      seenValid += int'(moveValid);
    end
    checkOutput("t3_bounce_valid", seenValid, 0);

    // Player 1 moves on cell 0, then player 2 offers cell 1 under back-pressure and wins.
    for (int m = 1; m <= 12; m++) applyStimulus(m <= 6 ? 9'h001 : 9'h000, 9'h094, 1, 0, 0, 0, 0);
    applyStimulus(9'h000, 9'h095, 0, 1, 0, 0, 0);
    for (int m = 1; m <= 12; m++) applyStimulus(m <= 6 ? 9'h002 : 9'h000, 9'h095, 0, 0, 0, 0, 0);
    for (int m = 1; m <= 5; m++) begin
      applyStimulus(9'h000, 9'h095, 0, 0, 0, 0, 0);
      checkOutput("t5_hold_valid", moveValid, 1);
      checkOutput("t5_hold_cell", moveCell, 1);
`ifndef TTT_TURN_TIMEOUT_EN
      checkOutput("t5_hold_player", movePlayer, 1);
`endif
    end
    applyStimulus(9'h000, 9'h095, 1, 0, 0, 0, 0);
    applyStimulus(9'h000, 9'h097, 0, 0, 0, 0, 0);
    checkOutput("t5_valid_drop", moveValid, 0);
    applyStimulus(9'h000, 9'h097, 0, 1, 1, 0, 0);
    applyStimulus(9'h000, 9'h097, 0, 0, 0, 0, 0);
    checkOutput("t5_over", gameOver, 1);
    checkOutput("t5_active", gameActive, 0);
`ifndef TTT_TURN_TIMEOUT_EN
    checkOutput("t5_winner", winner, 2);
`endif

    // Idle turn: skipped only when the timeout is built.
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(9'h000, 9'h000, 1, 0, 0, 0, 1);
    seenSkip = 0;
    for (int m = 1; m <= 20; m++) begin
      applyStimulus(9'h000, 9'h000, 1, 0, 0, 0, 0);
      seenSkip += int'(turnSkipped);
    end
`ifdef TTT_TURN_TIMEOUT_EN
    checkOutput("t6_skips", seenSkip, 1);
    checkOutput("t6_curr", currPlayer, 1);
`else
    checkOutput("t6_skips", seenSkip, 0);
    checkOutput("t6_curr", currPlayer, 0);
`endif

    // Random games against the model.
    hold = 0;
    rb = '0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 12);
        case ($urandom_range(0, 3))
          1: rb = 9'(1 << $urandom_range(0, 8));
          2: rb = 9'((1 << $urandom_range(0, 8)) | (1 << $urandom_range(0, 8)));
          default: rb = '0;
        endcase
      end
      hold--;
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
      applyStimulus(rb, 9'($urandom) & 9'($urandom), $urandom_range(0, 2) != 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
